dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, giving the number of 32-bit data memory words.
REQ-002 The block SHALL have parameter LATENCY, default 2, giving the number of cycles from request accept to response valid; legal range 1..15.
REQ-003 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-004 clock  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  initiator presents a load/store request.
REQ-007 req_ready  output  1  responder can accept a request this cycle.
REQ-008 req_write  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data.
REQ-011 req_wstrb  input  4  store byte enables; bit k enables bits 8k+7:8k (little-endian).
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  initiator can take the response.
REQ-014 rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-015 rsp_err  output  1  access was misaligned or out of range.

Function
REQ-016 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-017 req_ready SHALL be 1 only in IDLE; it SHALL be combinational from state only.
REQ-018 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1. On accept, write, addr, wdata and wstrb SHALL be latched, a 4-bit counter SHALL load LATENCY-1, and the FSM SHALL move to WAIT.
REQ-019 Request inputs SHALL be ignored outside the accept edge; changes after accept SHALL have no effect.
REQ-020 In WAIT with counter>0, the counter SHALL decrement each cycle.
REQ-021 In WAIT with counter=0, the memory access SHALL be performed on that edge, rsp_* SHALL be registered, and the FSM SHALL move to RESP. If accept is at edge N, rsp_valid SHALL first be 1 after edge N+LATENCY.
REQ-022 An access SHALL be an error if latched addr[1:0]≠0 or addr>>2 ≥ DEPTH_WORDS. An error SHALL leave memory unchanged, with rsp_err=1 and rsp_rdata=0.
REQ-023 A valid load SHALL give rsp_rdata = mem[addr>>2] and rsp_err=0.
REQ-024 A valid store SHALL write only the enabled bytes of mem[addr>>2], with rsp_rdata=0 and rsp_err=0. wstrb=0 SHALL be a legal no-op store with a normal response.
REQ-025 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until rsp_ready=1. On the handshake edge the FSM SHALL go to IDLE and rsp_valid SHALL fall.
REQ-026 req_ready SHALL rise the cycle after the response handshake; there SHALL be no same-cycle response-and-accept. Minimum spacing between accepts SHALL be LATENCY+2 cycles.
REQ-027 Exactly one request SHALL be outstanding at any time; there SHALL be no queuing.
REQ-028 A load SHALL observe every store whose response has completed earlier.
REQ-029 Memory contents SHALL initialise to zero at time 0.

Reset
REQ-030 reset=1 at an edge SHALL set: state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, latched request fields=0. Reset SHALL take priority over all other events.
REQ-031 Reset SHALL NOT clear memory contents.
REQ-032 Reset in WAIT before the access edge SHALL drop the request with no memory write and no response. Reset in RESP SHALL discard the pending response.
REQ-033 req_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-034 LATENCY=2: store addr 0x10, wdata 0xDEADBEEF, wstrb 0xF accepted at edge N -> rsp_valid after edge N+2, rsp_err=0. Then load 0x10 -> rsp_rdata=0xDEADBEEF.
REQ-035 Partial store: mem[4]=0x11223344, then store addr 0x10, wdata 0xAABBCCDD, wstrb 0b0101 -> load 0x10 returns 0x11BB33DD.
REQ-036 Errors: load 0x13 -> rsp_err=1, rsp_rdata=0. Store 0x1000 (word 1024, DEPTH 1024) -> rsp_err=1, and mem[0] is unchanged.
REQ-037 Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_* stable and req_ready=0 throughout. Assert rsp_ready -> rsp_valid falls next edge and req_ready=1 the following cycle.
REQ-038 Reset mid-op: store 0x20 = 0x55 accepted, reset asserted one cycle later (LATENCY=2) -> no response, and a load of 0x20 after reset returns the prior value.
REQ-039 LATENCY=1 back-to-back with req_valid held high and rsp_ready=1 -> accepts exactly every 3 cycles, and each rsp_valid lasts 1 cycle.

Source files
------------

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: load/store request and response handshake between an initiator and the data memory responder.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding word-addressed data memory with a fixed accept-to-response latency.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input logic             clock,
    input logic             reset,
    dmem_responder_if.slave bus
);
    localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t      state;
    logic [3:0]  count;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] mem [DEPTH_WORDS] = '{default: '0};
    logic        err;
    logic        access;
    logic [AW-1:0] idx;
    assign err    = (addr[1:0] != 2'b00) || ((addr >> 2) >= 32'(DEPTH_WORDS));
    assign idx    = addr[AW+1:2];
    assign access = !reset && state == WAIT && count == 4'd0;
    assign bus.req_ready = state == IDLE;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_rdata = rsp_rdata;
    assign bus.rsp_err   = rsp_err;
    // Memory is never reset; only a completed, in-range store touches it.
    always_ff @(posedge clock)
        if (access && write && !err)
            for (int k = 0; k < 4; k++)
                if (wstrb[k]) mem[idx][8*k +: 8] <= wdata[8*k +: 8];
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            write     <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            wstrb     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    write <= bus.req_write;
                    addr  <= bus.req_addr;
                    wdata <= bus.req_wdata;
                    wstrb <= bus.req_wstrb;
                    count <= 4'(LATENCY - 1);
                    state <= WAIT;
                end
                WAIT: if (count != 4'd0) count <= count - 4'd1;
                else begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= err;
                    rsp_rdata <= (err || write) ? '0 : mem[idx];
                    state     <= RESP;
                end
                RESP: if (bus.rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: random and directed load/store traffic scored against a flat word-array model;
// a second LATENCY=1 instance exercises back-to-back throughput.
module tb_dmem_responder;
    localparam int LAT   = 2;
    localparam int DEPTH = 1024;
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int hold = 0;
    bit rnd = 1'b0;
    exp_t q[$];
    logic [31:0] model [DEPTH];
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    dmem_responder_if bus();
    dmem_responder_if b1();
    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (.clock(clock), .reset(reset), .bus(bus));
    dmem_responder #(.DEPTH_WORDS(16), .LATENCY(1)) u1 (.clock(clock), .reset(reset), .bus(b1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Expected response is computed at accept time; one outstanding request keeps model order exact.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int t = 0;
        exp_t e;
        int i;
        @(negedge clock);
        while (!bus.req_ready && t < 200) begin
            @(negedge clock);
            t++;
        end
        if (!bus.req_ready) begin
            chk("req_ready_timeout", {31'b0, bus.req_ready}, 32'd1);
            return;
        end
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_wstrb = s;
        e.err   = (a % 4 != 0) || (a / 4 >= DEPTH);
        e.rdata = '0;
        if (!e.err) begin
            i = int'(a / 4);
            if (w) begin
                for (int k = 0; k < 4; k++)
                    if (s[k]) model[i][8*k +: 8] = d[8*k +: 8];
            end else e.rdata = model[i];
        end
        e.acc = cyc + 1;
        q.push_back(e);
        @(negedge clock);
        bus.req_valid = 1'b0;
        bus.req_write = 1'($urandom);
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        bus.req_wstrb = 4'($urandom);
    endtask

    task automatic drain();
        int t = 0;
        while ((q.size() != 0 || bus.rsp_valid) && t < 200) begin
            @(negedge clock);
            t++;
        end
        chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    initial begin : monitor
        bit pv = 1'b0;
        bit hs = 1'b0;
        logic [31:0] hr = '0;
        logic he = 1'b0;
        exp_t e;
        bus.rsp_ready = 1'b0;
        forever begin
            @(negedge clock);
            #1;
            if (reset) begin
                pv = 1'b0;
                hs = 1'b0;
                bus.rsp_ready = 1'b0;
            end else begin
                if (hs) begin
                    chk("valid_fall", {31'b0, bus.rsp_valid}, 32'd0);
                    chk("ready_after_hs", {31'b0, bus.req_ready}, 32'd1);
                end
                if (bus.rsp_valid) begin
                    chk("req_ready_in_resp", {31'b0, bus.req_ready}, 32'd0);
                    if (pv && !hs) begin
                        chk("hold_rdata", bus.rsp_rdata, hr);
                        chk("hold_err", {31'b0, bus.rsp_err}, {31'b0, he});
                    end else if (q.size() == 0) begin
                        chk("unexpected_rsp", {31'b0, bus.rsp_valid}, 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk("rdata", bus.rsp_rdata, e.rdata);
                        chk("err", {31'b0, bus.rsp_err}, {31'b0, e.err});
                        chk("latency", 32'(cyc), 32'(e.acc + LAT));
                        hr = bus.rsp_rdata;
                        he = bus.rsp_err;
                    end
                end
                pv = bus.rsp_valid;
                bus.rsp_ready = (hold > 0 && pv) ? 1'b0 : (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
                if (hold > 0 && pv) hold--;
                hs = pv && bus.rsp_ready;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1);
    end

    initial begin
        int last;
        int n_acc;
        int n_rsp;
        bit pv1;
        logic [31:0] a;
        int r;
        foreach (model[i]) model[i] = '0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0; bus.req_wstrb = '0;
        b1.req_valid = 1'b0; b1.req_write = 1'b0; b1.req_addr = '0; b1.req_wdata = '0; b1.req_wstrb = '0;
        b1.rsp_ready = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_rsp_err", {31'b0, bus.rsp_err}, 32'd0);
        chk("rst_u1_req_ready", {31'b0, b1.req_ready}, 32'd1);
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        issue(1'b0, 32'h10, 32'h0, 4'h0);
        issue(1'b1, 32'h10, 32'h11223344, 4'hF);
        issue(1'b1, 32'h10, 32'hAABBCCDD, 4'b0101);
        issue(1'b0, 32'h10, 32'h0, 4'h0);
        issue(1'b1, 32'h0, 32'hCAFEF00D, 4'hF);
        issue(1'b0, 32'h13, 32'h0, 4'h0);
        issue(1'b1, 32'h1000, 32'h12345678, 4'hF);
        issue(1'b0, 32'h0, 32'h0, 4'h0);
        issue(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0);
        issue(1'b0, 32'h10, 32'h0, 4'h0);
        issue(1'b0, 32'hFFC, 32'h0, 4'h0);
        drain();
        hold = 5;
        issue(1'b0, 32'h10, 32'h0, 4'h0);
        drain();
        issue(1'b1, 32'h20, 32'h12345678, 4'hF);
        drain();
        @(negedge clock);
        chk("idle_before_rst", {31'b0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h20; bus.req_wdata = 32'h55; bus.req_wstrb = 4'hF;
        @(negedge clock);
        bus.req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("midop_rst_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("midop_rst_valid", {31'b0, bus.rsp_valid}, 32'd0);
        repeat (5) @(negedge clock);
        issue(1'b0, 32'h20, 32'h0, 4'h0);
        drain();
        rnd = 1'b1;
        repeat (300) begin
            r = $urandom_range(0, 9);
            a = r < 7 ? {24'b0, 6'($urandom_range(0, 63)), 2'b00} :
                r == 7 ? 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(1, 3)) :
                r == 8 ? ($urandom | 32'h1000) & ~32'h3 : 32'hFFC;
            issue(1'($urandom), a, $urandom, 4'($urandom));
        end
        drain();
        rnd = 1'b0;
        @(negedge clock);
        b1.req_write = 1'b0; b1.req_addr = '0; b1.req_wdata = '0; b1.req_wstrb = '0;
        b1.rsp_ready = 1'b1; b1.req_valid = 1'b1;
        last = -1; n_acc = 0; n_rsp = 0; pv1 = 1'b0;
        for (int i = 0; i < 30; i++) begin
            #1;
            if (b1.req_ready) begin
                if (last >= 0) chk("b2b_spacing", 32'(i - last), 32'd3);
                last = i;
                n_acc++;
            end
            if (b1.rsp_valid) begin
                chk("b2b_pulse", {31'b0, pv1}, 32'd0);
                chk("b2b_rdata", b1.rsp_rdata, 32'd0);
                chk("b2b_err", {31'b0, b1.rsp_err}, 32'd0);
                n_rsp++;
            end
            pv1 = b1.rsp_valid;
            @(negedge clock);
        end
        b1.req_valid = 1'b0;
        chk("b2b_accepts", 32'(n_acc), 32'd10);
        chk("b2b_responses", 32'(n_rsp), 32'd10);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
